radix_2_mul: RTL
================

RADIX_2_MUL -- requirements
Module: radix_2_mul

Interface
REQ-001 SHALL have parameter DSIZE, default 8: width of operand, exponent and product.
REQ-002 SHALL have parameter PSIZE, default 8: width of the normalized mantissa, with binary point after the MSB (value = mant/2^(PSIZE-1)).
REQ-003 SHALL have port clock, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: input operands valid.
REQ-006 SHALL have port in_ready, output, 1: block can accept operands.
REQ-007 SHALL have port mant, input, PSIZE: unsigned normalized mantissa, matching the divider quotient format.
REQ-008 SHALL have port mexp, input, DSIZE: two's-complement exponent, matching the divider quoexp format.
REQ-009 SHALL have port operand, input, DSIZE: unsigned multiplier operand, e.g. the original divisor.
REQ-010 SHALL have port out_valid, output, 1: product valid.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts product.
REQ-012 SHALL have port product, output, DSIZE: unsigned rounded, saturated result.
REQ-013 SHALL have port ovf, output, 1: product was saturated.

Function
REQ-014 SHALL compute product = round(mant*operand*2^mexp / 2^(PSIZE-1)), rounding half-up, i.e. reconstruct the dividend from a quotient/exponent pair.
REQ-015 SHALL implement a FSM with states IDLE, MUL, SCALE, HOLD.
REQ-016 SHALL accept operands in IDLE only, with in_ready=1 exactly when in IDLE.
REQ-017 SHALL, on a handshake (in_valid & in_ready at an edge), register mant, mexp and operand, clear the PSIZE+DSIZE-bit accumulator, and enter MUL.
REQ-018 SHALL, in MUL, process one mantissa bit per cycle, LSB first, by shift-add; MUL SHALL last exactly PSIZE cycles, then go to SCALE.
REQ-019 SHALL, in SCALE, in one cycle, apply shift s = mexp-(PSIZE-1) to the full product P, register the result, and enter HOLD.
REQ-020 SHALL, for s>=0, use P<<s.
REQ-021 SHALL, for s<0, use (P>>-s) plus bit (-s-1) of P.
REQ-022 SHALL, for -s > PSIZE+DSIZE, produce 0.
REQ-023 SHALL, if the result exceeds 2^DSIZE-1 (including any bit lost by the left shift), set product=2^DSIZE-1 and ovf=1; otherwise ovf=0.
REQ-024 SHALL assert out_valid only in HOLD.
REQ-025 SHALL hold product and ovf stable while out_valid=1 and out_ready=0.
REQ-026 SHALL, on out_valid & out_ready at an edge, return to IDLE; in_ready SHALL rise on the next cycle, with no same-cycle turnaround.
REQ-027 SHALL have a latency of PSIZE+2 cycles from the accepting edge to the first edge at which out_valid=1.
REQ-028 SHALL give a throughput of at most one operation per PSIZE+3 cycles.
REQ-029 SHALL produce product=0, ovf=0 when mant=0 or operand=0, still with full latency.
REQ-030 SHALL ignore in_valid outside IDLE and SHALL NOT alter registered operands.

Reset
REQ-031 SHALL, while rst=0, immediately force state=IDLE, in_ready=1, out_valid=0, product=0, ovf=0, accumulator=0, regardless of clock.
REQ-032 SHALL abort an operation on reset mid-MUL/SCALE/HOLD with no output produced; the first edge after rst returns to 1 SHALL be able to accept new operands.

Verification (DSIZE=PSIZE=8)
REQ-033 SHALL cover: mant=0x80, mexp=0, operand=100 -> product=100, ovf=0, out_valid at accept+10.
REQ-034 SHALL cover: mant=0xC0, mexp=1, operand=20 -> product=60, ovf=0.
REQ-035 SHALL cover: mant=0x80, mexp=0xFF (-1), operand=3 -> product=2 (1.5 rounded up), ovf=0.
REQ-036 SHALL cover: mant=0xFF, mexp=7, operand=255 -> product=255, ovf=1.
REQ-037 SHALL cover: out_ready held 0 for 5 cycles after out_valid -> product/ovf stable, in_ready=0, new in_valid ignored; release -> in_ready=1 next cycle.
REQ-038 SHALL cover: rst pulsed low during MUL cycle 3 -> out_valid=0, product=0 immediately; the next operation (mant=0x80, mexp=0, operand=7) -> product=7.
REQ-039 SHALL include a bench scoreboard that checks random operands against a real-valued model with a ±0.5 LSB tolerance, plus exact saturation checks.

Source files
------------

// File: rtl/radix_2_mul.sv
// rtl/radix_2_mul.sv - Rebuilds a dividend from a normalized quotient/exponent pair:
// a serial shift-add multiply followed by one rounding and saturating scale step.
module radix_2_mul #(
    parameter int DSIZE = 8,
    parameter int PSIZE = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PSIZE-1:0] mant,
    input  logic [DSIZE-1:0] mexp,
    input  logic [DSIZE-1:0] operand,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DSIZE-1:0] product,
    output logic             ovf
);

    localparam int W  = PSIZE + DSIZE;
    localparam int SW = DSIZE + $clog2(PSIZE + 1) + 2;
    localparam int CW = (PSIZE > 1) ? $clog2(PSIZE) : 1;

    typedef enum logic [1:0] {IDLE, MUL, SCALE, HOLD} state_t;

    state_t           state_q;
    logic [PSIZE-1:0] mant_q;
    logic [DSIZE-1:0] mexp_q;
    logic [DSIZE-1:0] operand_q;
    logic [W-1:0]     acc_q;
    logic [CW-1:0]    cnt_q;
    logic [DSIZE-1:0] product_q;
    logic             ovf_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             mant_bit;
    logic [W-1:0]     addend;
    logic [W-1:0]     acc_d;

    logic [SW-1:0]    s;
    logic [SW-1:0]    mag;
    logic [W:0]       res;
    logic             lost;
    logic             rnd_bit;
    logic [DSIZE-1:0] product_d;
    logic             ovf_d;

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign product   = product_q;
    assign ovf       = ovf_q;

    // One mantissa bit per MUL cycle, least significant first.
    always_comb begin
        mant_bit = |(mant_q & (PSIZE'(1) << cnt_q));
        addend   = mant_bit ? (W'(operand_q) << cnt_q) : '0;
        acc_d    = acc_q + addend;
    end

    // Scale by 2^(mexp-(PSIZE-1)); right shifts round half-up via the last bit shifted out.
    always_comb begin
        s         = SW'(signed'(mexp_q)) - SW'(PSIZE - 1);
        mag       = s[SW-1] ? -s : s;
        lost      = 1'b0;
        rnd_bit   = 1'b0;
        res       = '0;
        if (!s[SW-1]) begin
            res = {1'b0, acc_q << mag};
            if (32'(mag) >= 32'(W)) begin
                lost = |acc_q;
            end else begin
                lost = |(acc_q >> (32'(W) - 32'(mag)));
            end
        end else if (32'(mag) <= 32'(W)) begin
            rnd_bit = |(acc_q & (W'(1) << (mag - SW'(1))));
            res     = {1'b0, acc_q >> mag} + {{W{1'b0}}, rnd_bit};
        end
        ovf_d     = lost | (|res[W:DSIZE]);
        product_d = ovf_d ? '1 : res[DSIZE-1:0];
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            mexp_q      <= '0;
            operand_q   <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            product_q   <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        mant_q     <= mant;
                        mexp_q     <= mexp;
                        operand_q  <= operand;
                        acc_q      <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= MUL;
                    end
                end
                MUL: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(PSIZE - 1)) begin
                        state_q <= SCALE;
                    end
                end
                SCALE: begin
                    product_q   <= product_d;
                    ovf_q       <= ovf_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
